// File: rtl/phase_ramp_pkg.sv
// Shared encodings and helpers for the FOG phase-ramp generator.
// Mode codes, FSM state constants, gain default and a saturate helper.
package phase_ramp_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_CLOSED = 2'd1;
    localparam logic [1:0] MODE_OPEN   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ACC   = 2'd1;
    localparam state_t S_SCALE = 2'd2;
    localparam state_t S_OUT   = 2'd3;

    localparam int GAIN_INIT_DEF = 5;

    function automatic logic signed [63:0] sat_fn(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/phase_ramp_sat.sv
// Combinational signed clip from IN_W bits to OUT_W bits.
// Narrowing saturates to +2^(OUT_W-1)-1 / -2^(OUT_W-1); widening sign-extends.
module phase_ramp_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);

    generate
        if (IN_W <= OUT_W) begin : g_ext
            assign out_o = OUT_W'($signed(in_i));
        end else begin : g_clip
            logic [IN_W-OUT_W:0] top;
            logic                ovf;
            assign top = in_i[IN_W-1:OUT_W-1];
            assign ovf = !((&top) || (~|top));
            assign out_o = !ovf ? in_i[OUT_W-1:0] :
                           in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                          {1'b0, {(OUT_W-1){1'b1}}};
        end
    endgenerate

endmodule

// File: rtl/phase_ramp_gen_wrap.sv
// Phase-ramp generator with serrodyne 2pi reset for the FOG modulator DAC.
// Optional macro PHASE_RAMP_BUMPLESS_EN rescales acc on a closed-loop gain change.
module phase_ramp_gen_wrap
    import phase_ramp_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int GAIN_W     = 4,
    parameter int GAIN_INIT  = GAIN_INIT_DEF,
    parameter int WRAP_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mod_trig,
    input  logic [1:0]            i_mode,
    input  logic [ACC_W-1:0]      i_step,
    input  logic [OUT_W-1:0]      i_mod,
    input  logic [GAIN_W-1:0]     i_gain_sel,
    input  logic [OUT_W-1:0]      i_v2pi,
    input  logic                  i_wrap_en,
    output logic [OUT_W-1:0]      o_phase,
    output logic                  o_valid,
    output logic [OUT_W-1:0]      o_ramp,
    output logic [ACC_W-1:0]      o_ramp_pre,
    output logic [WRAP_CNT_W-1:0] o_wrap_cnt,
    output logic [1:0]            o_wrap_pulse,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_gain_change
);

    localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_INIT);

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [GAIN_W-1:0]       gain_q, gain_d;
    logic [GAIN_W-1:0]       gain_prev_q, gain_prev_d;
    logic signed [ACC_W-1:0] step_q, step_d;
    logic signed [OUT_W-1:0] mod_q, mod_d;
    logic [OUT_W-1:0]        v2pi_q, v2pi_d;
    logic                    wrap_en_q, wrap_en_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] ramp_q, ramp_d;
    logic signed [OUT_W-1:0] phase_q, phase_d;
    logic [WRAP_CNT_W-1:0]   wcnt_q, wcnt_d;
    logic                    valid_q, valid_d;
    logic [1:0]              wpulse_q, wpulse_d;
    logic                    ovr_q, ovr_d;
    logic                    gchg_q, gchg_d;

    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W:0]   acc_adj;
    logic signed [ACC_W:0]   acc_clip_in;
    logic signed [ACC_W-1:0] acc_clip;
    logic [GAIN_W-1:0]       shift;
    logic signed [ACC_W-1:0] r_raw;
    logic signed [ACC_W-1:0] r_wrap;
    logic signed [ACC_W-1:0] v2pi_ext;
    logic signed [ACC_W-1:0] half_ext;
    logic signed [ACC_W-1:0] v2pi_sh;
    logic                    wrap_act;
    logic                    wrap_up;
    logic                    wrap_dn;
    logic signed [OUT_W-1:0] ramp_clip;
    logic signed [OUT_W:0]   out_sum;
    logic signed [OUT_W-1:0] phase_clip;

`ifdef PHASE_RAMP_BUMPLESS_EN
    localparam int SH_MAX = (1 << GAIN_W) - 1;
    localparam int EXT_W  = ACC_W + SH_MAX;

    logic [GAIN_W-1:0]       gdelta_up;
    logic [GAIN_W-1:0]       gdelta_dn;
    logic [EXT_W-1:0]        acc_up_ext;
    logic signed [ACC_W-1:0] acc_up;

    assign gdelta_up  = gain_q - gain_prev_q;
    assign gdelta_dn  = gain_prev_q - gain_q;
    assign acc_up_ext = EXT_W'(acc_q) << gdelta_up;

    phase_ramp_sat #(.IN_W(EXT_W), .OUT_W(ACC_W)) u_sat_up (
        .in_i  (acc_up_ext),
        .out_o (acc_up)
    );

    // Keep acc >>> gain continuous across a closed-loop gain change
    always_comb begin
        acc_base = acc_q;
        if (mode_q == MODE_CLOSED && gain_q != gain_prev_q) begin
            if (gain_q > gain_prev_q) acc_base = acc_up;
            else                      acc_base = acc_q >>> gdelta_dn;
        end
    end
`else
    assign acc_base = acc_q;
`endif

    assign acc_sum = {acc_base[ACC_W-1], acc_base}
                   + {step_q[ACC_W-1], step_q};

    assign shift    = (mode_q == MODE_CLOSED) ? gain_q : '0;
    assign r_raw    = acc_q >>> shift;
    assign v2pi_ext = ACC_W'(v2pi_q);
    assign half_ext = v2pi_ext >>> 1;
    assign v2pi_sh  = v2pi_ext << shift;

    assign wrap_act = wrap_en_q && (v2pi_q != '0)
                   && (mode_q == MODE_CLOSED || mode_q == MODE_OPEN);
    assign wrap_up  = wrap_act && (r_raw >= half_ext);
    assign wrap_dn  = wrap_act && (r_raw < -half_ext);

    always_comb begin
        r_wrap  = r_raw;
        acc_adj = {acc_q[ACC_W-1], acc_q};
        unique case (1'b1)
            wrap_up: begin
                r_wrap  = r_raw - v2pi_ext;
                acc_adj = {acc_q[ACC_W-1], acc_q} - {1'b0, v2pi_sh};
            end
            wrap_dn: begin
                r_wrap  = r_raw + v2pi_ext;
                acc_adj = {acc_q[ACC_W-1], acc_q} + {1'b0, v2pi_sh};
            end
            default: ;
        endcase
    end

    // One acc clip serves both the accumulate and the wrap-adjust stages
    assign acc_clip_in = (state_q == S_SCALE) ? acc_adj : acc_sum;

    phase_ramp_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W)) u_sat_acc (
        .in_i  (acc_clip_in),
        .out_o (acc_clip)
    );

    phase_ramp_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_ramp (
        .in_i  (r_wrap),
        .out_o (ramp_clip)
    );

    assign out_sum = {ramp_q[OUT_W-1], ramp_q} + {mod_q[OUT_W-1], mod_q};

    phase_ramp_sat #(.IN_W(OUT_W+1), .OUT_W(OUT_W)) u_sat_out (
        .in_i  (out_sum),
        .out_o (phase_clip)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        gain_d      = gain_q;
        gain_prev_d = gain_prev_q;
        step_d      = step_q;
        mod_d       = mod_q;
        v2pi_d      = v2pi_q;
        wrap_en_d   = wrap_en_q;
        acc_d       = acc_q;
        ramp_d      = ramp_q;
        phase_d     = phase_q;
        wcnt_d      = wcnt_q;
        valid_d     = 1'b0;
        wpulse_d    = 2'b00;
        gchg_d      = 1'b0;
        ovr_d       = i_mod_trig && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (i_mod_trig) begin
                    mode_d      = i_mode;
                    gain_prev_d = gain_q;
                    gain_d      = i_gain_sel;
                    step_d      = i_step;
                    mod_d       = i_mod;
                    v2pi_d      = i_v2pi;
                    wrap_en_d   = i_wrap_en;
                    state_d     = S_ACC;
                end
            end
            S_ACC: begin
                gchg_d = (gain_q != gain_prev_q);
                unique case (mode_q)
                    MODE_OFF:  acc_d = '0;
                    MODE_HOLD: acc_d = acc_q;
                    default:   acc_d = acc_clip;
                endcase
                state_d = S_SCALE;
            end
            S_SCALE: begin
                acc_d    = acc_clip;
                ramp_d   = (mode_q == MODE_OFF) ? '0 : ramp_clip;
                wpulse_d = {wrap_dn, wrap_up};
                if (wrap_up) wcnt_d = wcnt_q + 1'b1;
                if (wrap_dn) wcnt_d = wcnt_q - 1'b1;
                state_d  = S_OUT;
            end
            default: begin
                phase_d = phase_clip;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_OFF;
            gain_q      <= GAIN_RST;
            gain_prev_q <= GAIN_RST;
            step_q      <= '0;
            mod_q       <= '0;
            v2pi_q      <= '0;
            wrap_en_q   <= 1'b0;
            acc_q       <= '0;
            ramp_q      <= '0;
            phase_q     <= '0;
            wcnt_q      <= '0;
            valid_q     <= 1'b0;
            wpulse_q    <= 2'b00;
            ovr_q       <= 1'b0;
            gchg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            gain_q      <= gain_d;
            gain_prev_q <= gain_prev_d;
            step_q      <= step_d;
            mod_q       <= mod_d;
            v2pi_q      <= v2pi_d;
            wrap_en_q   <= wrap_en_d;
            acc_q       <= acc_d;
            ramp_q      <= ramp_d;
            phase_q     <= phase_d;
            wcnt_q      <= wcnt_d;
            valid_q     <= valid_d;
            wpulse_q    <= wpulse_d;
            ovr_q       <= ovr_d;
            gchg_q      <= gchg_d;
        end
    end

    assign o_phase       = phase_q;
    assign o_valid       = valid_q;
    assign o_ramp        = ramp_q;
    assign o_ramp_pre    = acc_q;
    assign o_wrap_cnt    = wcnt_q;
    assign o_wrap_pulse  = wpulse_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_overrun     = ovr_q;
    assign o_gain_change = gchg_q;

endmodule
